// File: rtl/keypad_pkg.sv
// Shared types and default timing for the keypad matrix scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD,
        RELEASE
    } scan_state_t;

    localparam int unsigned SCAN_DIV_DEFAULT         = 4096;
    localparam int unsigned DEBOUNCE_SAMPLES_DEFAULT = 4;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer; resets to all ones to match idle pulled-up lines.
module sync2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/keypad_matrix_scanner.sv
// Row-scanning keypad reader: drives one row low per dwell, debounces a single key
// and reports it as a registered code with a one-cycle valid strobe.
module keypad_matrix_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned ROWS             = 4,
    parameter int unsigned COLS             = 4,
    parameter int unsigned SCAN_DIV         = SCAN_DIV_DEFAULT,
    parameter int unsigned DEBOUNCE_SAMPLES = DEBOUNCE_SAMPLES_DEFAULT,
    localparam int unsigned CODE_W          = $clog2(ROWS * COLS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [COLS-1:0]   col_in,
    output logic [ROWS-1:0]   row_out,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    output logic              key_held
);

    localparam int unsigned RW  = $clog2(ROWS);
    localparam int unsigned CW  = $clog2(COLS);
    localparam int unsigned DCW = $clog2(SCAN_DIV);
    localparam int unsigned DW  = $clog2(DEBOUNCE_SAMPLES + 1);

    logic [COLS-1:0] col_s;
    logic [COLS-1:0] pressed;

    scan_state_t     state_q, state_d;
    logic [DCW-1:0]  dwell_q, dwell_d;
    logic [RW-1:0]   row_q, row_d, row_next;
    logic [RW-1:0]   cap_row_q, cap_row_d;
    logic [CW-1:0]   cap_col_q, cap_col_d;
    logic [CW-1:0]   low_col;
    logic [DW-1:0]   deb_q, deb_d, deb_inc;
    logic [CODE_W-1:0] code_q, code_d;
    logic            valid_q, valid_d;
    logic            held_q, held_d;
    logic            tick;
    logic            cap_pressed;
    logic            deb_done;

    sync2 #(
        .WIDTH (COLS)
    ) u_col_sync (
        .clk   (clk),
        .reset (reset),
        .d     (col_in),
        .q     (col_s)
    );

    assign pressed     = ~col_s;
    assign tick        = (dwell_q == DCW'(SCAN_DIV - 1));
    assign cap_pressed = pressed[cap_col_q];
    assign row_next    = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
    assign deb_inc     = deb_q + DW'(1);
    assign deb_done    = (deb_inc == DW'(DEBOUNCE_SAMPLES));

    // Descending scan so the lowest pressed column is the final assignment.
    always_comb begin
        low_col = '0;
        for (int c = int'(COLS) - 1; c >= 0; c--) begin
            if (pressed[c]) begin
                low_col = CW'(c);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        dwell_d   = tick ? '0 : dwell_q + DCW'(1);
        row_d     = row_q;
        cap_row_d = cap_row_q;
        cap_col_d = cap_col_q;
        deb_d     = deb_q;
        code_d    = code_q;
        valid_d   = 1'b0;
        held_d    = held_q;

        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (pressed == '0) begin
                        row_d = row_next;
                    end else begin
                        cap_row_d = row_q;
                        cap_col_d = low_col;
                        deb_d     = DW'(1);
                        state_d   = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (!cap_pressed) begin
                        row_d   = row_next;
                        state_d = SCAN;
                    end else if (deb_done) begin
                        code_d  = CODE_W'(cap_row_q) * CODE_W'(COLS) + CODE_W'(cap_col_q);
                        valid_d = 1'b1;
                        held_d  = 1'b1;
                        state_d = HELD;
                    end else begin
                        deb_d = deb_inc;
                    end
                end
                HELD: begin
                    if (!cap_pressed) begin
                        deb_d   = DW'(1);
                        state_d = RELEASE;
                    end
                end
                RELEASE: begin
                    if (cap_pressed) begin
                        state_d = HELD;
                    end else if (deb_done) begin
                        held_d  = 1'b0;
                        row_d   = row_next;
                        state_d = SCAN;
                    end else begin
                        deb_d = deb_inc;
                    end
                end
                default: state_d = SCAN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= SCAN;
            dwell_q   <= '0;
            row_q     <= '0;
            cap_row_q <= '0;
            cap_col_q <= '0;
            deb_q     <= '0;
            code_q    <= '0;
            valid_q   <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dwell_q   <= dwell_d;
            row_q     <= row_d;
            cap_row_q <= cap_row_d;
            cap_col_q <= cap_col_d;
            deb_q     <= deb_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            held_q    <= held_d;
        end
    end

    assign row_out   = ~(ROWS'(1) << row_q);
    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_held  = held_q;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Bench for keypad_matrix_scanner: a physical keypad model drives the columns and a
// per-dwell behavioural model predicts row drive, code, strobe and held flag.
module tb_keypad_matrix_scanner;

    localparam int ROWS     = 4;
    localparam int COLS     = 4;
    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [COLS-1:0] col_in;
    logic [ROWS-1:0] row_out;
    logic [3:0]      key_code;
    logic            key_valid;
    logic            key_held;

    // Physical key switches, bit r*COLS+c.
    logic [ROWS*COLS-1:0] keys = '0;

    int checks = 0;
    int errors = 0;
    int valid_seen = 0;

    // Reference model, advanced once per dwell period.
    int m_row, m_lock, m_run, m_rel, m_code;
    bit m_held, m_fire;

    keypad_matrix_scanner #(
        .ROWS             (ROWS),
        .COLS             (COLS),
        .SCAN_DIV         (SCAN_DIV),
        .DEBOUNCE_SAMPLES (DEB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .col_in    (col_in),
        .row_out   (row_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    always_comb begin
        col_in = '1;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (keys[r*COLS+c] && !row_out[r]) col_in[c] = 1'b0;
            end
        end
    end

    task automatic model_reset();
        m_row = 0; m_lock = -1; m_run = 0; m_rel = 0; m_code = 0;
        m_held = 0; m_fire = 0;
    endtask

    // Applies the accept/abort/release rules to the sample taken at the end of a dwell.
    task automatic model_tick();
        logic [COLS-1:0] hit;
        hit = keys[m_row*COLS +: COLS];
        m_fire = 0;
        if (m_lock < 0) begin
            if (hit == '0) begin
                m_row = (m_row + 1) % ROWS;
            end else begin
                for (int c = COLS - 1; c >= 0; c--) if (hit[c]) m_lock = c;
                m_run = 1;
            end
        end else if (!m_held) begin
            if (hit[m_lock]) begin
                m_run++;
                if (m_run == DEB) begin
                    m_held = 1; m_fire = 1; m_rel = 0;
                    m_code = m_row * COLS + m_lock;
                end
            end else begin
                m_lock = -1;
                m_row = (m_row + 1) % ROWS;
            end
        end else begin
            if (!hit[m_lock]) begin
                m_rel++;
                if (m_rel == DEB) begin
                    m_held = 0; m_lock = -1;
                    m_row = (m_row + 1) % ROWS;
                end
            end else begin
                m_rel = 0;
            end
        end
    endtask

    // One dwell period: entered and left #1 after the edge that starts a dwell.
    task automatic run_dwell();
        logic [ROWS-1:0] exp_row;
        for (int i = 0; i < SCAN_DIV; i++) begin
            exp_row = ~(4'b0001 << m_row);
            checks += 4;
            if (row_out !== exp_row) begin
                errors++;
                $display("FAIL row_out got %b expected %b at %0t", row_out, exp_row, $time);
            end
            if (key_valid !== (m_fire && i == 0)) begin
                errors++;
                $display("FAIL key_valid got %b expected %b at %0t", key_valid,
                         (m_fire && i == 0), $time);
            end
            if (key_held !== m_held) begin
                errors++;
                $display("FAIL key_held got %b expected %b at %0t", key_held, m_held, $time);
            end
            if (key_code !== 4'(m_code)) begin
                errors++;
                $display("FAIL key_code got %0d expected %0d at %0t", key_code, m_code, $time);
            end
            if (key_valid === 1'b1) valid_seen++;
            @(posedge clk);
            #1;
        end
        model_tick();
    endtask

    task automatic wait_held(input int budget);
        for (int d = 0; d < budget && !m_held; d++) run_dwell();
        checks++;
        if (!m_held) begin
            errors++;
            $display("FAIL wait_held budget of %0d dwells expired", budget);
        end
        run_dwell();
    endtask

    task automatic wait_released(input int budget);
        for (int d = 0; d < budget && m_held; d++) run_dwell();
        checks++;
        if (m_held) begin
            errors++;
            $display("FAIL wait_released budget of %0d dwells expired", budget);
        end
    endtask

    task automatic test_reset();
        keys = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        checks += 4;
        if (row_out !== 4'b1110) begin
            errors++; $display("FAIL reset_row got %b expected 1110", row_out);
        end
        if (key_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid got %b expected 0", key_valid);
        end
        if (key_held !== 1'b0) begin
            errors++; $display("FAIL reset_held got %b expected 0", key_held);
        end
        if (key_code !== 4'd0) begin
            errors++; $display("FAIL reset_code got %0d expected 0", key_code);
        end
    endtask

    task automatic test_idle_scan();
        logic [ROWS-1:0] exp_r;
        keys = '0;
        valid_seen = 0;
        for (int d = 0; d < 9; d++) begin
            exp_r = 4'b1111 ^ (4'b0001 << (d % ROWS));
            checks++;
            if (row_out !== exp_r) begin
                errors++; $display("FAIL idle_row got %b expected %b dwell %0d", row_out, exp_r, d);
            end
            run_dwell();
        end
        checks++;
        if (valid_seen != 0) begin
            errors++; $display("FAIL idle_valid got %0d pulses expected 0", valid_seen);
        end
    endtask

    task automatic test_press();
        valid_seen = 0;
        keys = '0;
        keys[2*COLS+1] = 1'b1;
        wait_held(12);
        run_dwell();
        checks += 4;
        if (valid_seen != 1) begin
            errors++; $display("FAIL press_pulses got %0d expected 1", valid_seen);
        end
        if (key_code !== 4'd9) begin
            errors++; $display("FAIL press_code got %0d expected 9", key_code);
        end
        if (key_held !== 1'b1) begin
            errors++; $display("FAIL press_held got %b expected 1", key_held);
        end
        if (row_out !== 4'b1011) begin
            errors++; $display("FAIL press_row got %b expected 1011", row_out);
        end
        keys = '0;
        wait_released(DEB + 1);
        run_dwell();
    endtask

    task automatic test_short_press();
        keys = '0;
        valid_seen = 0;
        for (int d = 0; d < 8 && m_row != 1; d++) run_dwell();
        keys[1*COLS+3] = 1'b1;
        run_dwell();
        keys = '0;
        run_dwell();
        checks += 3;
        if (row_out !== 4'b1011) begin
            errors++; $display("FAIL short_row got %b expected 1011", row_out);
        end
        if (key_code !== 4'd9) begin
            errors++; $display("FAIL short_code got %0d expected 9", key_code);
        end
        if (valid_seen != 0) begin
            errors++; $display("FAIL short_pulses got %0d expected 0", valid_seen);
        end
        run_dwell();
    endtask

    task automatic test_second_key();
        valid_seen = 0;
        keys = '0;
        keys[2*COLS+1] = 1'b1;
        wait_held(16);
        keys[0] = 1'b1;
        repeat (4) run_dwell();
        checks += 2;
        if (valid_seen != 1) begin
            errors++; $display("FAIL second_pulses got %0d expected 1", valid_seen);
        end
        if (row_out !== 4'b1011) begin
            errors++; $display("FAIL second_row got %b expected 1011", row_out);
        end
        keys[2*COLS+1] = 1'b0;
        repeat (DEB - 1) run_dwell();
        checks++;
        if (key_held !== 1'b1) begin
            errors++; $display("FAIL second_early_release got %b expected 1", key_held);
        end
        run_dwell();
        checks++;
        if (key_held !== 1'b0) begin
            errors++; $display("FAIL second_release got %b expected 0", key_held);
        end
        wait_held(16);
        checks += 2;
        if (valid_seen != 2) begin
            errors++; $display("FAIL second_detect got %0d pulses expected 2", valid_seen);
        end
        if (key_code !== 4'd0) begin
            errors++; $display("FAIL second_code got %0d expected 0", key_code);
        end
        keys = '0;
        wait_released(DEB + 1);
    endtask

    task automatic test_multi_column();
        valid_seen = 0;
        keys = '0;
        keys[1*COLS+0] = 1'b1;
        keys[1*COLS+2] = 1'b1;
        wait_held(16);
        run_dwell();
        checks += 2;
        if (valid_seen != 1) begin
            errors++; $display("FAIL multi_pulses got %0d expected 1", valid_seen);
        end
        if (key_code !== 4'd4) begin
            errors++; $display("FAIL multi_code got %0d expected 4", key_code);
        end
        keys = '0;
        wait_released(DEB + 1);
    endtask

    task automatic test_bounce_then_reset();
        valid_seen = 0;
        keys = '0;
        keys[2*COLS+1] = 1'b1;
        wait_held(16);
        for (int b = 0; b < 2; b++) begin
            keys[2*COLS+1] = 1'b0;
            run_dwell();
            keys[2*COLS+1] = 1'b1;
            run_dwell();
        end
        checks += 2;
        if (key_held !== 1'b1) begin
            errors++; $display("FAIL bounce_held got %b expected 1", key_held);
        end
        if (valid_seen != 1) begin
            errors++; $display("FAIL bounce_pulses got %0d expected 1", valid_seen);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        checks += 3;
        if (row_out !== 4'b1110) begin
            errors++; $display("FAIL midreset_row got %b expected 1110", row_out);
        end
        if (key_held !== 1'b0 || key_valid !== 1'b0) begin
            errors++; $display("FAIL midreset_flags got held %b valid %b expected 0 0",
                               key_held, key_valid);
        end
        if (key_code !== 4'd0) begin
            errors++; $display("FAIL midreset_code got %0d expected 0", key_code);
        end
        wait_held(16);
        checks += 2;
        if (valid_seen != 2) begin
            errors++; $display("FAIL redetect_pulses got %0d expected 2", valid_seen);
        end
        if (key_code !== 4'd9) begin
            errors++; $display("FAIL redetect_code got %0d expected 9", key_code);
        end
        keys = '0;
        wait_released(DEB + 1);
    endtask

    task automatic test_random();
        int hold;
        hold = 0;
        for (int d = 0; d < 120; d++) begin
            if (hold == 0) begin
                keys = '0;
                if ($urandom_range(0, 2) != 0) begin
                    keys[$urandom_range(0, ROWS*COLS-1)] = 1'b1;
                    if ($urandom_range(0, 3) == 0) keys[$urandom_range(0, ROWS*COLS-1)] = 1'b1;
                end
                hold = $urandom_range(1, 8);
            end
            run_dwell();
            hold--;
        end
        keys = '0;
        repeat (2*DEB + 2) run_dwell();
    endtask

    initial begin
        test_reset();
        test_idle_scan();
        test_press();
        test_short_press();
        test_second_key();
        test_multi_column();
        test_bounce_then_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_matrix_scanner.md
Name: keypad_matrix_scanner

Overview:
Reads a passive ROWS x COLS key-switch matrix. It drives one row low at a time, samples the column lines, and debounces a single key. It reports that key as a registered code with a one-cycle valid strobe. It is the input-side counterpart of the LED row/column matrix drivers and sits beside them in top, clocked from the same internal oscillator domain.

Parameters:
ROWS, 4, number of matrix rows driven (2..8)
COLS, 4, number of column inputs sampled (2..8)
SCAN_DIV, 4096, clk cycles per row dwell; must be >= 4
DEBOUNCE_SAMPLES, 4, consecutive identical samples to accept a press or release (>= 2)

Ports:
clk  in  1  system clock (single clock domain)
reset  in  1  synchronous, active-high reset
col_in  in  COLS  raw column lines; active-low; pulled up off-chip; asynchronous
row_out  out  ROWS  row drive; active-low; exactly one bit low at all times
key_code  out  CODE_W=$clog2(ROWS*COLS)  row_idx*COLS + col_idx of the accepted key; holds its value until the next accepted press
key_valid  out  1  one-cycle pulse when a press is accepted
key_held  out  1  high from the key_valid cycle until the release is accepted

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high, sampled only on posedge clk.
- Reset values:
  - row_idx=0, so row_out = ~(1<<0) (4'b1110 at default)
  - key_code=0, key_valid=0, key_held=0
  - state=SCAN; dwell and debounce counters = 0; synchronizer flops = all ones
- Synchronizer: col_in passes through a 2-flop synchronizer (col_s).
- Dwell counter: counts 0..SCAN_DIV-1 and wraps.
  - The sample tick is the cycle the counter equals SCAN_DIV-1; col_s is evaluated only on that cycle.
  - The counter runs in every state.
- Column select: pressed = ~col_s. If several bits are set, the lowest col index wins.
- SCAN state:
  - On a tick with pressed==0: row_idx advances, wrapping ROWS-1 -> 0.
  - On a tick with pressed!=0: capture cap_row=row_idx and cap_col=lowest set index, set deb_cnt=1, go to DEBOUNCE. Row rotation freezes.
- DEBOUNCE state (row frozen):
  - On a tick with pressed[cap_col]=1: deb_cnt++.
  - When deb_cnt reaches DEBOUNCE_SAMPLES: on the next cycle key_code = cap_row*COLS+cap_col, key_valid=1 (exactly one cycle), key_held=1. Go to HELD.
  - On a tick with pressed[cap_col]=0: abort with no output change. Go to SCAN, and row_idx advances to the next row.
- HELD state (row frozen, key_held=1):
  - Other columns and other rows are ignored, so no second key is reported.
  - On a tick with pressed[cap_col]=0: deb_cnt=1, go to RELEASE.
- RELEASE state (row frozen, key_held=1):
  - On a tick with pressed[cap_col]=0: deb_cnt++.
  - When deb_cnt reaches DEBOUNCE_SAMPLES: key_held=0 next cycle, row_idx advances, go to SCAN.
  - On a tick with pressed[cap_col]=1: return to HELD. No new key_valid.
- Press latency from the first low sample: (DEBOUNCE_SAMPLES-1)*SCAN_DIV + 1 cycles to key_valid.
- Arithmetic:
  - key_code is computed at CODE_W width; the multiply is by a constant.
  - deb_cnt width is $clog2(DEBOUNCE_SAMPLES+1).
- Reset mid-operation: reset forces all reset values on the next edge. A key still physically held after reset is re-detected and re-debounced, and produces a fresh key_valid.
- key_valid is never asserted in SCAN, HELD or RELEASE, except on the single cycle after the DEBOUNCE -> HELD transition.

Decomposition:
- Package keypad_pkg:
  - scan_state_t enum {SCAN, DEBOUNCE, HELD, RELEASE} (logic [1:0])
  - localparam defaults for SCAN_DIV and DEBOUNCE_SAMPLES
- Sub-module sync2: parameterised-width 2-flop synchronizer with synchronous active-high reset to all ones, instantiated for col_in.
- Dwell counter, FSM and output registers live in the top of this block.

Test Plan:
(Bench uses SCAN_DIV=4, DEBOUNCE_SAMPLES=3, ROWS=COLS=4. The keypad model is col_in[c] = ~|(pressed[r][c] & ~row_out[r]).)
1. Reset, no keys -> row_out = 1110,1101,1011,0111, each for 4 cycles, then wraps to 1110; key_valid and key_held stay 0.
2. Hold key (r2,c1) steady -> row_out freezes at 1011; after 3 low samples key_code=9 and key_valid is high for exactly 1 cycle; key_held=1 and stays high.
3. Press (r1,c3) for only 1 sample, then release -> no key_valid; key_code keeps its old value; scanning resumes at row_out=1011.
4. Hold (r2,c1) until key_held=1, then also press (r0,c0) -> no second key_valid. Release (r2,c1): key_held falls after 3 high samples. (r0,c0) is then detected and reported with key_code=0.
5. Press (r1,c0) and (r1,c2) simultaneously -> single key_valid with key_code=4.
6. In HELD, bounce release (high 1 sample, low 1 sample) -> key_held stays 1, no new key_valid. Assert reset for 1 cycle -> next edge row_out=1110 and all outputs 0; the still-held key is reported again with key_valid.
